// File: rtl/switch_bounce_gen_if.sv
// Command/status bundle between a bounce generator and its controller.
// The controller owns the i_* side; the generator drives the o_* side.
interface switch_bounce_gen_if #(
  parameter int W_NB   = 4,
  parameter int W_GAP  = 8,
  parameter int W_HOLD = 12
) ();

  logic              i_en;
  logic              i_cmd;
  logic [W_NB-1:0]   i_n_bounce;
  logic [W_GAP-1:0]  i_gap_mask;
  logic [W_HOLD-1:0] i_hold;
  logic              o_sig;
  logic              o_busy;
  logic              o_done;

  modport master (
    output i_en,
    output i_cmd,
    output i_n_bounce,
    output i_gap_mask,
    output i_hold,
    input  o_sig,
    input  o_busy,
    input  o_done
  );

  modport slave (
    input  i_en,
    input  i_cmd,
    input  i_n_bounce,
    input  i_gap_mask,
    input  i_hold,
    output o_sig,
    output o_busy,
    output o_done
  );

endinterface

// File: rtl/switch_bounce_gen.sv
// Switch-bounce emulator: drives an odd number of LFSR-spaced toggles
// toward the commanded level, then holds it before signalling done.
module switch_bounce_gen #(
  parameter int          W_NB      = 4,
  parameter int          W_GAP     = 8,
  parameter int          W_HOLD    = 12,
  parameter bit          IS_PULLUP = 1'b0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic                clk,
  input logic                rstn,
  switch_bounce_gen_if.slave bus
);

  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  localparam logic [15:0] TAPS = 16'hB400;

  localparam logic [W_GAP:0]  G1 = 1;
  localparam logic [W_NB:0]   T1 = 1;
  localparam logic [W_HOLD-1:0] H1 = 1;

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    HOLD
  } state_e;

  state_e            state_q;
  logic              sig_q;
  logic              level_q;
  logic              busy_q;
  logic              done_q;
  logic              target_q;
  logic [W_NB:0]     ntog_q;
  logic [W_NB:0]     tog_q;
  logic [W_GAP-1:0]  mask_q;
  logic [W_GAP:0]    gap_q;
  logic [W_HOLD-1:0] hold_q;
  logic [W_HOLD-1:0] hcnt_q;

  logic [15:0]       lfsr_q;
  logic [15:0]       lfsr_d;
  logic [W_GAP:0]    gap_st_d;
  logic [W_GAP:0]    gap_run_d;
  logic              start_d;

  assign lfsr_d = {1'b0, lfsr_q[15:1]}
                ^ (lfsr_q[0] ? TAPS : 16'h0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Gap for the first toggle uses the live mask; later gaps the latched one.
  assign gap_st_d  = {1'b0, lfsr_q[W_GAP-1:0] & bus.i_gap_mask} + G1;
  assign gap_run_d = {1'b0, lfsr_q[W_GAP-1:0] & mask_q} + G1;

  assign start_d = bus.i_en && (bus.i_cmd != level_q);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      sig_q    <= IS_PULLUP;
      level_q  <= IS_PULLUP;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      target_q <= IS_PULLUP;
      ntog_q   <= '0;
      tog_q    <= '0;
      mask_q   <= '0;
      gap_q    <= '0;
      hold_q   <= '0;
      hcnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          sig_q  <= level_q;
          busy_q <= 1'b0;
          if (start_d) begin
            target_q <= bus.i_cmd;
            ntog_q   <= {bus.i_n_bounce, 1'b1};
            mask_q   <= bus.i_gap_mask;
            hold_q   <= bus.i_hold;
            sig_q    <= ~level_q;
            tog_q    <= T1;
            gap_q    <= gap_st_d;
            busy_q   <= 1'b1;
            state_q  <= BOUNCE;
          end
        end
        BOUNCE: begin
          if (tog_q == ntog_q) begin
            hcnt_q  <= hold_q;
            state_q <= HOLD;
          end else if (gap_q == G1) begin
            sig_q <= ~sig_q;
            tog_q <= tog_q + T1;
            gap_q <= gap_run_d;
          end else begin
            gap_q <= gap_q - G1;
          end
        end
        HOLD: begin
          sig_q <= target_q;
          // A hold of 0 or 1 both finish on the first HOLD cycle.
          if (hcnt_q <= H1) begin
            hcnt_q  <= '0;
            done_q  <= 1'b1;
            level_q <= target_q;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            hcnt_q <= hcnt_q - H1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_sig  = sig_q;
  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;

endmodule
